// File: rtl/adc_capture_buffer_if.sv
// adc_capture_buffer_if
//   Bus between the capture buffer, the ADC front end and the UART transmitter.
//   master : drives ADC sample, arm/force_trig pulses and trigger level;
//            receives the UART byte stream and status.
//   slave  : the capture buffer itself.
//   Signals:
//     adcIn[7:0]       ADC sample, unsigned
//     arm              1-cycle pulse, arm the trigger
//     force_trig       1-cycle pulse, trigger immediately
//     trig_level[7:0]  rising-edge trigger threshold
//     dataOut[7:0]     byte for the UART, held between strobes
//     readyToTransmit  1-cycle strobe, dataOut valid
//     busy             high while not idle
//     capture_done     1-cycle pulse at the end of a burst
interface adc_capture_buffer_if;
    logic [7:0] adcIn;
    logic       arm;
    logic       force_trig;
    logic [7:0] trig_level;
    logic [7:0] dataOut;
    logic       readyToTransmit;
    logic       busy;
    logic       capture_done;

    modport master (
        output adcIn, arm, force_trig, trig_level,
        input  dataOut, readyToTransmit, busy, capture_done
    );

    modport slave (
        input  adcIn, arm, force_trig, trig_level,
        output dataOut, readyToTransmit, busy, capture_done
    );
endinterface

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer
//   Triggered capture stage between a parallel 8-bit ADC and a UART transmitter.
//   Samples the ADC every SAMPLE_DIV clocks; once triggered (rising crossing of
//   trig_level, or force_trig) it records DEPTH samples into RAM, then streams a
//   0xAA header followed by the samples as single-cycle byte strobes spaced
//   TX_GAP clocks apart.
//   Ports:
//     clk  system clock
//     rst  synchronous reset, active high
//     bus  adc_capture_buffer_if.slave (ADC input, controls, UART byte stream, status)
module adc_capture_buffer #(
    parameter int DEPTH      = 256,
    parameter int ADDR_W     = 8,
    parameter int SAMPLE_DIV = 27,
    parameter int TX_GAP     = 3744
) (
    input  logic                   clk,
    input  logic                   rst,
    adc_capture_buffer_if.slave    bus
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int GAP_W = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TX_GAP - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   TX_LAST   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, SEND} state_t;

    state_t              state, state_n;
    logic [DIV_W-1:0]    div;
    logic                strobe;
    logic [7:0]          prev;
    logic                prev_vld;
    logic [ADDR_W-1:0]   addr;
    logic [GAP_W-1:0]    gap;
    logic                gap_end;
    logic [ADDR_W:0]     tx_idx;     // data bytes already sent (0..DEPTH)
    logic [7:0]          data_q;
    logic                rtt_q;
    logic                done_q;
    logic                trig_hit;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [7:0]          mem [DEPTH];
    logic [7:0]          ram_q;

    assign strobe  = (div == DIV_LAST);
    assign gap_end = (gap == GAP_LAST);
    // trig_level == 0 can never satisfy prev < trig_level, so it never fires.
    assign trig_hit = prev_vld && (prev < bus.trig_level) && (bus.adcIn >= bus.trig_level);

    assign bus.dataOut         = data_q;
    assign bus.readyToTransmit = rtt_q;
    assign bus.capture_done    = done_q;
    assign bus.busy            = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            // done_q is high exactly in the cycle after the burst ends; an arm
            // landing there belongs to the old burst and is dropped.
            IDLE:    if (bus.arm && !done_q) state_n = ARMED;
            ARMED:   if (bus.force_trig || (strobe && trig_hit)) state_n = CAPTURE;
            CAPTURE: if (strobe && addr == ADDR_LAST) state_n = SEND;
            SEND:    if (gap_end && tx_idx == TX_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Trigger sample (or a forced trigger landing on a strobe) goes to RAM[0].
    assign wr_en   = strobe && ((state == ARMED && state_n == CAPTURE) || state == CAPTURE);
    assign wr_addr = (state == ARMED) ? '0 : addr;

    // RAM: no reset, synchronous read. Read address tracks the next byte to
    // send so ram_q is ready well before its strobe (TX_GAP >= 2).
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.adcIn;
        ram_q <= mem[tx_idx[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            prev     <= '0;
            prev_vld <= 1'b0;
            addr     <= '0;
            gap      <= '0;
            tx_idx   <= '0;
            data_q   <= '0;
            rtt_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            div    <= strobe ? '0 : div + 1'b1;
            rtt_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: if (state_n == ARMED) prev_vld <= 1'b0;
                ARMED: begin
                    if (strobe) begin
                        prev     <= bus.adcIn;
                        prev_vld <= 1'b1;
                    end
                    if (state_n == CAPTURE) addr <= strobe ? ADDR_W'(1) : '0;
                end
                CAPTURE: begin
                    if (strobe) addr <= addr + 1'b1;   // wraps to 0 after the last slot
                    if (state_n == SEND) begin
                        data_q <= 8'hAA;
                        rtt_q  <= 1'b1;
                        gap    <= '0;
                        tx_idx <= '0;
                    end
                end
                SEND: begin
                    if (gap_end) begin
                        gap <= '0;
                        if (tx_idx == TX_LAST) begin
                            done_q <= 1'b1;
                        end else begin
                            data_q <= ram_q;
                            rtt_q  <= 1'b1;
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer
//   Directed bench for adc_capture_buffer (DEPTH=4, SAMPLE_DIV=2, TX_GAP=8).
//   A queue-based model of the capture/send rules is checked against the DUT
//   every cycle; literal burst expectations pin both the model and the DUT.
module tb_adc_capture_buffer;
    localparam int DEPTH = 4, ADDR_W = 2, SAMPLE_DIV = 2, TX_GAP = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    adc_capture_buffer_if bus();

    adc_capture_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SAMPLE_DIV(SAMPLE_DIV), .TX_GAP(TX_GAP))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // model: 0 idle, 1 armed, 2 capturing, 3 sending
    int         m_mode, m_div, m_tick;
    bit         m_en = 0, m_have_prev, m_rtt, m_done;
    logic [7:0] m_prev, m_data;
    logic [7:0] m_samp[$], m_txq[$], m_bytes[$];
    // observed DUT stream
    logic [7:0] d_bytes[$];
    int         d_cyc[$];
    int         d_done_cyc = -1;
    logic [7:0] d_prev;
    bit         d_prev_rtt, rst_edge;

    task automatic m_emit();
        m_data = m_txq.pop_front();
        m_rtt  = 1'b1;
        m_bytes.push_back(m_data);
    endtask

    always @(posedge clk) begin
        bit stb, done_prev;
        cyc++;
        rst_edge = rst;
        if (rst) begin
            m_en = 1; m_mode = 0; m_div = 0; m_tick = 0;
            m_have_prev = 0; m_rtt = 0; m_done = 0; m_data = 8'h00;
            m_samp.delete(); m_txq.delete();
        end else if (m_en) begin
            stb = (m_div == SAMPLE_DIV - 1);
            m_div = (m_div + 1) % SAMPLE_DIV;
            done_prev = m_done;
            m_rtt = 0; m_done = 0;
            case (m_mode)
                0: if (bus.arm && !done_prev) begin m_mode = 1; m_have_prev = 0; end
                1: begin
                    if ((stb && m_have_prev && m_prev < bus.trig_level && bus.adcIn >= bus.trig_level)
                        || bus.force_trig) begin
                        m_samp.delete();
                        if (stb) m_samp.push_back(bus.adcIn);
                        m_mode = 2;
                    end else if (stb) begin
                        m_prev = bus.adcIn; m_have_prev = 1;
                    end
                end
                2: if (stb) begin
                    m_samp.push_back(bus.adcIn);
                    if (m_samp.size() == DEPTH) begin
                        m_txq.delete();
                        m_txq.push_back(8'hAA);
                        foreach (m_samp[i]) m_txq.push_back(m_samp[i]);
                        m_emit();
                        m_tick = 0; m_mode = 3;
                    end
                end
                default: begin
                    m_tick++;
                    if (m_tick == TX_GAP) begin
                        m_tick = 0;
                        if (m_txq.size() > 0) m_emit();
                        else begin m_done = 1; m_mode = 0; end
                    end
                end
            endcase
        end
        #1;
        if (m_en) begin
            chk("dataOut", bus.dataOut, m_data);
            chk("readyToTransmit", bus.readyToTransmit, m_rtt);
            chk("busy", bus.busy, m_mode != 0);
            chk("capture_done", bus.capture_done, m_done);
            if (!rst_edge) begin
                if (!bus.readyToTransmit) chk("dataOut_stable", bus.dataOut, d_prev);
                chk("rtt_back_to_back", bus.readyToTransmit && d_prev_rtt, 0);
            end
            if (bus.readyToTransmit) begin d_bytes.push_back(bus.dataOut); d_cyc.push_back(cyc); end
            if (bus.capture_done) d_done_cyc = cyc;
            d_prev = bus.dataOut;
            d_prev_rtt = bus.readyToTransmit;
        end
    end

    task automatic clear_logs();
        d_bytes.delete(); d_cyc.delete(); m_bytes.delete(); d_done_cyc = -1;
    endtask
    task automatic pulse_arm();
        @(negedge clk) bus.arm = 1'b1;
        @(negedge clk) bus.arm = 1'b0;
    endtask
    task automatic pulse_force();
        @(negedge clk) bus.force_trig = 1'b1;
        @(negedge clk) bus.force_trig = 1'b0;
    endtask
    // One SAMPLE_DIV window: exactly one sample strobe sees this value.
    task automatic hold(input logic [7:0] v);
        bus.adcIn = v;
        repeat (SAMPLE_DIV) @(negedge clk);
    endtask
    task automatic wait_done(input int bound);
        int n = 0;
        while (d_done_cyc < 0 && n < bound) begin @(negedge clk); n++; end
        chk("capture_done_seen", d_done_cyc >= 0, 1);
    endtask
    task automatic wait_bytes(input int cnt, input int bound);
        int n = 0;
        while (d_bytes.size() < cnt && n < bound) begin @(negedge clk); n++; end
        chk("strobes_seen", d_bytes.size() >= cnt, 1);
    endtask
    task automatic check_burst(input string tag, input logic [7:0] exp [5]);
        chk({tag, "_strobe_count"}, d_bytes.size(), 5);
        chk({tag, "_model_count"}, m_bytes.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < d_bytes.size()) chk({tag, "_byte"}, d_bytes[i], exp[i]);
            if (i < m_bytes.size()) chk({tag, "_model_byte"}, m_bytes[i], exp[i]);
            if (i > 0 && i < d_cyc.size()) chk({tag, "_spacing"}, d_cyc[i] - d_cyc[i-1], TX_GAP);
        end
        if (d_cyc.size() == 5) chk({tag, "_done_delay"}, d_done_cyc - d_cyc[4], TX_GAP);
    endtask

    initial begin
        bus.adcIn = 8'h00; bus.arm = 1'b0; bus.force_trig = 1'b0; bus.trig_level = 8'h80;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1. reset values
        chk("reset_dataOut", bus.dataOut, 8'h00);
        chk("reset_rtt", bus.readyToTransmit, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.capture_done, 0);

        // 2. rising trigger
        clear_logs();
        bus.adcIn = 8'h10;
        pulse_arm();
        hold(8'h10); hold(8'h90); hold(8'hA0); hold(8'hB0); hold(8'hC0);
        wait_done(200);
        check_burst("rise", '{8'hAA, 8'h90, 8'hA0, 8'hB0, 8'hC0});

        // 3. flat signal above level never triggers; force_trig does
        clear_logs();
        repeat (3) @(negedge clk);
        bus.adcIn = 8'h90;
        pulse_arm();
        repeat (50) @(negedge clk);
        chk("flat_busy", bus.busy, 1);
        chk("flat_no_strobe", d_bytes.size(), 0);
        pulse_force();
        wait_done(200);
        check_burst("flat", '{8'hAA, 8'h90, 8'h90, 8'h90, 8'h90});

        // 3b. trig_level 0 never triggers
        clear_logs();
        bus.trig_level = 8'h00;
        pulse_arm();
        hold(8'h00); hold(8'hFF); hold(8'h00); hold(8'hFF);
        chk("lvl0_busy", bus.busy, 1);
        chk("lvl0_no_strobe", d_bytes.size(), 0);
        pulse_force();
        wait_done(200);
        bus.trig_level = 8'h80;

        // 4. ignored controls: force in IDLE, arm in CAPTURE/SEND/done cycle
        clear_logs();
        pulse_force();
        @(negedge clk);
        chk("force_idle_busy", bus.busy, 0);
        bus.adcIn = 8'h10;
        pulse_arm();
        hold(8'h10); hold(8'h20); hold(8'h85);
        bus.adcIn = 8'h86; bus.arm = 1'b1;
        @(negedge clk) bus.arm = 1'b0;
        @(negedge clk);
        hold(8'h87); hold(8'h88);
        wait_bytes(2, 200);
        pulse_arm();
        wait_done(200);
        bus.arm = 1'b1;                 // lands in the capture_done cycle
        @(negedge clk) bus.arm = 1'b0;
        repeat (4) @(negedge clk);
        chk("arm_on_done_busy", bus.busy, 0);
        check_burst("ignore", '{8'hAA, 8'h85, 8'h86, 8'h87, 8'h88});

        // 5. reset mid-SEND, then a fresh burst
        clear_logs();
        bus.adcIn = 8'h55;
        pulse_arm();
        pulse_force();
        wait_bytes(2, 200);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("midsend_rtt", bus.readyToTransmit, 0);
        chk("midsend_busy", bus.busy, 0);
        repeat (20) @(negedge clk);
        chk("midsend_no_more", d_bytes.size(), 2);
        clear_logs();
        bus.adcIn = 8'h33;
        pulse_arm();
        pulse_force();
        wait_done(200);
        check_burst("fresh", '{8'hAA, 8'h33, 8'h33, 8'h33, 8'h33});

        // 6. back-to-back captures, spacing and hold-stability
        clear_logs();
        bus.adcIn = 8'h10;
        pulse_arm();
        hold(8'h10); hold(8'h91); hold(8'h92); hold(8'h93); hold(8'h94);
        wait_done(200);
        check_burst("b2b_a", '{8'hAA, 8'h91, 8'h92, 8'h93, 8'h94});
        clear_logs();
        bus.adcIn = 8'h05;
        pulse_arm();
        hold(8'h05); hold(8'hF0); hold(8'h0F); hold(8'hF0); hold(8'h00);
        wait_done(200);
        check_burst("b2b_b", '{8'hAA, 8'hF0, 8'h0F, 8'hF0, 8'h00});

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
